main_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single `main_bus_if` among up to `NREQ` bus masters, such as the CPU testbench and a DMA engine. It hands out exactly one grant at a time and holds it for one complete bus transaction: one address cycle followed by `BURST` data cycles. It revokes a grant that is never used. It sits beside the main bus and watches only `AddrValid`; the masters and the memory controller keep the existing bus protocol unchanged.

---
 rtl/main_bus_arbiter_if.sv | 26 ++
 rtl/main_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_main_bus_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/main_bus_arbiter_if.sv
// Arbitration sideband for the main bus: request/grant lines plus the
// address-valid strobe the arbiter watches to track transaction boundaries.
interface main_bus_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic            AddrValid;
  logic [NREQ-1:0] gnt;
  logic [OW-1:0]   owner;
  logic            busy;
  logic            timeout_err;

  // Bus masters (and whatever models them) drive requests and the strobe
  modport master (
    output req, AddrValid,
    input  gnt, owner, busy, timeout_err
  );

  // The arbiter observes requests and the strobe, and produces the grant
  modport slave (
    input  req, AddrValid,
    output gnt, owner, busy, timeout_err
  );
endinterface

// File: rtl/main_bus_arbiter.sv
// Round-robin arbiter for the main bus. Holds one grant for an address cycle
// plus BURST data cycles, hands off back-to-back without an idle cycle, and
// revokes a grant that sits unused for TIMEOUT cycles.
module main_bus_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input logic                clk,
  input logic                resetH,
  main_bus_arbiter_if.slave  bus
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] gnt_q, gnt_nx;
  logic [OW-1:0]   owner_q, owner_nx;
  logic [OW-1:0]   last_q, last_nx;
  logic [BW-1:0]   beat_q, beat_nx;
  logic [WW-1:0]   wait_q, wait_nx;
  logic            busy_q, busy_nx;
  logic            terr_q, terr_nx;

  logic            pick_any_c;
  logic [OW-1:0]   pick_idx_c;

  // Round-robin search: first requester at or after (last+1), wrapping
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_any_c = 1'b0;
    pick_idx_c = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_q) + k) % NREQ;
      if (!pick_any_c && bus.req[idx]) begin
        pick_any_c = 1'b1;
        pick_idx_c = OW'(idx);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_q;
    owner_nx = owner_q;
    last_nx  = last_q;
    beat_nx  = beat_q;
    wait_nx  = wait_q;
    terr_nx  = 1'b0;

    unique case (state)
      IDLE: begin
        // AddrValid here is a protocol violation and is deliberately ignored
        if (pick_any_c) begin
          gnt_nx   = NREQ'(1) << pick_idx_c;
          owner_nx = pick_idx_c;
          last_nx  = pick_idx_c;
          wait_nx  = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (bus.AddrValid) begin
          beat_nx  = '0;
          state_nx = XFER;
        end else if (!bus.req[owner_q]) begin
          gnt_nx   = '0;
          state_nx = IDLE;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          gnt_nx   = '0;
          terr_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          wait_nx = wait_q + 1'b1;
        end
      end
      XFER: begin
        // Grant is held for the whole burst regardless of req or AddrValid
        if (beat_q == BW'(BURST - 1)) begin
          if (pick_any_c) begin
            gnt_nx   = NREQ'(1) << pick_idx_c;
            owner_nx = pick_idx_c;
            last_nx  = pick_idx_c;
            wait_nx  = '0;
            state_nx = GRANT;
          end else begin
            gnt_nx   = '0;
            state_nx = IDLE;
          end
        end else begin
          beat_nx = beat_q + 1'b1;
        end
      end
      default: begin
        gnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (resetH) begin
      state   <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      beat_q  <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      gnt_q   <= gnt_nx;
      owner_q <= owner_nx;
      last_q  <= last_nx;
      beat_q  <= beat_nx;
      wait_q  <= wait_nx;
      busy_q  <= busy_nx;
      terr_q  <= terr_nx;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Bench for main_bus_arbiter: directed scenarios followed by random traffic.
// A transaction-level model predicts grant ownership each cycle; predictions
// are queued by the driver and compared by an independent monitor.
module tb_main_bus_arbiter;
  localparam int N       = 2;
  localparam int BURST   = 4;
  localparam int TIMEOUT = 8;
  localparam int OW      = 1;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [OW-1:0] owner;
    logic          busy;
    logic          terr;
  } exp_t;

  logic clk;
  logic resetH;

  main_bus_arbiter_if #(.NREQ(N)) bus ();

  main_bus_arbiter #(
    .NREQ    (N),
    .BURST   (BURST),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk    (clk),
    .resetH (resetH),
    .bus    (bus)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  // Reference model: who holds the bus, whether its burst has started,
  // and how many cycles it has spent in the current phase.
  int m_holder = -1;
  int m_prev   = N - 1;
  int m_owner  = 0;
  int m_count  = 0;
  bit m_burst  = 1'b0;
  bit m_terr   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_prev + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit waiting();
    return (m_holder >= 0) && !m_burst;
  endfunction

  task automatic take(input int w);
    m_holder = w;
    m_prev   = w;
    m_owner  = w;
    m_burst  = 1'b0;
    m_count  = 0;
  endtask

  task automatic model_step(input bit rst, input logic [N-1:0] r, input bit av);
    int w;
    m_terr = 1'b0;
    if (rst) begin
      m_holder = -1;
      m_prev   = N - 1;
      m_owner  = 0;
      m_burst  = 1'b0;
      m_count  = 0;
    end else if (m_holder < 0) begin
      w = rr_pick(r);
      if (w >= 0) take(w);
    end else if (m_burst) begin
      m_count++;
      if (m_count == BURST) begin
        w = rr_pick(r);
        if (w >= 0) take(w);
        else m_holder = -1;
      end
    end else if (av) begin
      m_burst = 1'b1;
      m_count = 0;
    end else if (!r[m_holder]) begin
      m_holder = -1;
    end else begin
      m_count++;
      if (m_count == TIMEOUT) begin
        m_holder = -1;
        m_terr   = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic drive(input bit rst, input logic [N-1:0] r, input bit av);
    exp_t e;
    logic [N-1:0] g;
    @(negedge clk);
    resetH        = rst;
    bus.req       = r;
    bus.AddrValid = av;
    model_step(rst, r, av);
    g = '0;
    if (m_holder >= 0) g[m_holder] = 1'b1;
    e.gnt   = g;
    e.owner = OW'(m_owner);
    e.busy  = (m_holder >= 0);
    e.terr  = m_terr;
    exp_q.push_back(e);
    name_q.push_back(phase);
  endtask

  // Monitor: compare DUT outputs just after each active edge
  always @(posedge clk) begin
    exp_t  e;
    string nm;
    #1;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.owner !== e.owner ||
          bus.busy !== e.busy || bus.timeout_err !== e.terr) begin
        failures++;
        $display("FAIL %s @%0t: got gnt=%b owner=%0d busy=%b terr=%b, expected gnt=%b owner=%0d busy=%b terr=%b",
                 nm, $time, bus.gnt, bus.owner, bus.busy, bus.timeout_err,
                 e.gnt, e.owner, e.busy, e.terr);
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    resetH        = 1'b1;
    bus.req       = '0;
    bus.AddrValid = 1'b0;

    phase = "reset";
    repeat (3) drive(1'b1, 2'b00, 1'b0);
    phase = "idle";
    repeat (6) drive(1'b0, 2'b00, 1'b0);

    // Single requester, address one cycle after the grant appears
    phase = "single";
    for (int c = 0; c < 10; c++)
      drive(1'b0, (c < 3) ? 2'b01 : 2'b00, waiting() && m_count == 1);

    // Two continuous requesters, address issued immediately on grant
    phase = "fairness";
    repeat (30) drive(1'b0, 2'b11, waiting());
    phase = "drain";
    repeat (8) drive(1'b0, 2'b00, 1'b0);

    // Grant never used
    phase = "timeout";
    repeat (12) drive(1'b0, 2'b01, 1'b0);
    repeat (3) drive(1'b0, 2'b00, 1'b0);

    // Master 1 drops its request two cycles into its grant
    phase = "release";
    for (int c = 0; c < 20; c++) begin
      if (m_holder == 1 && m_count >= 2) break;
      drive(1'b0, 2'b11, 1'b0);
    end
    repeat (4) drive(1'b0, 2'b01, 1'b0);
    repeat (3) drive(1'b0, 2'b00, 1'b0);

    // Reset during the second data cycle
    phase = "reset_burst";
    for (int c = 0; c < 20; c++) begin
      if (m_burst && m_count == 1) break;
      drive(1'b0, 2'b11, waiting());
    end
    drive(1'b1, 2'b11, 1'b0);
    repeat (6) drive(1'b0, 2'b11, waiting());
    repeat (8) drive(1'b0, 2'b00, 1'b0);

    // Stray strobe while idle
    phase = "stray_av";
    repeat (4) drive(1'b0, 2'b00, 1'b1);

    // Random traffic with occasional resets and stray strobes
    phase = "random";
    rq = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      drive($urandom_range(0, 199) == 0, rq,
            waiting() ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue: %0d predictions left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
